// File: rtl/dmem_debug_arbiter_if.sv
// Shared data-memory port bundle: CPU load/store side, debug read side and BRAM side.
// The arbiter takes the slave view; the surrounding wrapper or bench takes the master view.
interface dmem_debug_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_re;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_debug_arbiter.sv
// Data-memory port arbiter: CPU has priority, a pending debug read is forced through
// after MAX_WAIT lost cycles at the cost of a single CPU stall cycle.
//
// Handshakes: the CPU side has no valid/ready pair; an access presented with cpu_stall=1
// is not taken and must be held and retried the next cycle. The debug side is a 4-phase
// level handshake: dbg_req rises, dbg_ack rises with dbg_rdata valid, dbg_req falls,
// dbg_ack falls; only then can the next request issue.
module dmem_debug_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  localparam int WCW     = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_debug_arbiter_if.slave bus,
  output logic [1:0]        fsm_state,
  output logic [WCW-1:0]    wait_cnt,
  output logic [ADDR_W-1:0] issued_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cpu_acc;

  assign cpu_acc       = bus.cpu_re | bus.cpu_we;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.dbg_ack   = ack_q;
  assign bus.dbg_rdata = rdata_q;
  assign fsm_state     = state_q;
  assign wait_cnt      = wait_q;
  assign issued_addr   = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    ack_d         = ack_q;
    rdata_d       = rdata_q;
    addr_d        = addr_q;
    bus.mem_en    = cpu_acc;
    bus.mem_we    = bus.cpu_we;
    bus.mem_addr  = bus.cpu_addr;
    bus.cpu_stall = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.dbg_req) begin
          wait_d = '0;
        end else if (cpu_acc && (wait_q < WAIT_LIMIT)) begin
          wait_d = wait_q + WCW'(1);
        end else begin
          // Debug read takes the port; a colliding CPU access is refused this cycle only.
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b0;
          bus.mem_addr  = bus.dbg_addr;
          bus.cpu_stall = cpu_acc;
          addr_d        = bus.dbg_addr;
          state_d       = READ;
        end
      end
      READ: begin
        rdata_d = bus.mem_rdata;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if (!bus.dbg_req) begin
          ack_d   = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.cpu_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_debug_arbiter.sv
// Directed bench for dmem_debug_arbiter: vector table for the basic debug and forced-read
// flows, hand sequences for store collision, address sweep, mid-read reset and idle gap.
module tb_dmem_debug_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;
  localparam int WCW      = $clog2(MAX_WAIT + 1);

  logic              clk;
  logic              rst;
  logic [1:0]        fsm_state;
  logic [WCW-1:0]    wait_cnt;
  logic [ADDR_W-1:0] issued_addr;

  dmem_debug_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_debug_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .fsm_state   (fsm_state),
    .wait_cnt    (wait_cnt),
    .issued_addr (issued_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with backdoor preload port
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_rdata_r;
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      mem_rdata_r <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_r;

  // ack rising-edge counter
  int   ack_rises;
  logic ack_prev;
  initial begin ack_rises = 0; ack_prev = 1'b0; end
  always @(negedge clk) begin
    if (bus.dbg_ack && !ack_prev) ack_rises++;
    ack_prev = bus.dbg_ack;
  end

  // scoreboard
  int n_cmp;
  int n_err;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic re, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic req, input logic [ADDR_W-1:0] da);
    @(posedge clk); #1;
    bus.cpu_re = re; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.dbg_req = req; bus.dbg_addr = da;
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int k;
    k = 0;
    while (bus.dbg_ack !== lvl && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(bus.dbg_ack), 32'(lvl));
  endtask

  // vector table
  typedef struct {
    logic              re, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              req;
    logic [ADDR_W-1:0] daddr;
    logic              en_e, we_e;
    logic [ADDR_W-1:0] maddr_e;
    logic              stall_e, ack_e, chk_rd;
    logic [DATA_W-1:0] rd_e;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic re, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd,
                              logic req, logic [ADDR_W-1:0] da, logic en_e, logic we_e,
                              logic [ADDR_W-1:0] ma_e, logic st_e, logic ack_e, logic chk_rd,
                              logic [DATA_W-1:0] rd_e);
    vec_t v;
    v.re = re; v.we = we; v.addr = a; v.wdata = wd; v.req = req; v.daddr = da;
    v.en_e = en_e; v.we_e = we_e; v.maddr_e = ma_e; v.stall_e = st_e;
    v.ack_e = ack_e; v.chk_rd = chk_rd; v.rd_e = rd_e;
    return v;
  endfunction

  initial begin
    n_cmp = 0; n_err = 0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // idle CPU debug read of addr 5 (mem[5]=0xA)
    tv.push_back(mk(0,0,0,0, 1,5, 1,0,5, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0, 1,5, 0,0,0, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0, 1,5, 0,0,0, 0,1, 1,32'hA));
    tv.push_back(mk(0,0,0,0, 0,5, 0,0,0, 0,1, 1,32'hA));
    tv.push_back(mk(0,0,0,0, 0,5, 0,0,0, 0,0, 1,32'hA));
    // CPU loads every cycle; debug read of addr 3 forced through on the 9th cycle
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(1,0,ADDR_W'(100+k),0, 1,3, 1,0,ADDR_W'(100+k), 0,0, 0,0));
    tv.push_back(mk(1,0,108,0, 1,3, 1,0,3,   1,0, 0,0));
    tv.push_back(mk(1,0,108,0, 1,3, 1,0,108, 0,0, 0,0));
    tv.push_back(mk(1,0,109,0, 1,3, 1,0,109, 0,1, 1,7));
    tv.push_back(mk(1,0,110,0, 0,3, 1,0,110, 0,1, 1,7));
    tv.push_back(mk(1,0,111,0, 0,3, 1,0,111, 0,0, 1,7));

    // reset with a CPU access and debug request pending: outputs must stay quiet
    rst = 1'b1;
    bus.cpu_re = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd9; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 10'd5;
    @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_ack", 32'(bus.dbg_ack), 0);
    chk("rst_rdata", bus.dbg_rdata, 0);
    chk("rst_state", 32'(fsm_state), 0);
    chk("rst_wait", 32'(wait_cnt), 0);
    bus.cpu_re = 1'b0; bus.dbg_req = 1'b0;
    bd_write(5, 32'hA);
    bd_write(3, 32'h7);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].re, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].req, tv[i].daddr);
      @(negedge clk);
      chk($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(tv[i].en_e));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(tv[i].we_e));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tv[i].maddr_e));
      chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(tv[i].stall_e));
      chk($sformatf("v%0d_ack", i), 32'(bus.dbg_ack), 32'(tv[i].ack_e));
      if (tv[i].chk_rd) chk($sformatf("v%0d_rdata", i), bus.dbg_rdata, tv[i].rd_e);
    end

    // preload 10,9,...,1 and sweep addresses 0..9
    drive(0,0,0,0, 0,0);
    for (int i = 0; i < 10; i++) bd_write(ADDR_W'(i), DATA_W'(10 - i));
    for (int i = 0; i < 10; i++) exp_q.push_back(DATA_W'(10 - i));
    begin
      int rises0;
      rises0 = ack_rises;
      for (int i = 0; i < 10; i++) begin
        drive(0,0,0,0, 1,ADDR_W'(i));
        wait_ack(1'b1, $sformatf("sweep%0d_ack_hi", i));
        chk($sformatf("sweep%0d_rdata", i), bus.dbg_rdata, exp_q.pop_front());
        drive(0,0,0,0, 0,ADDR_W'(i));
        wait_ack(1'b0, $sformatf("sweep%0d_ack_lo", i));
      end
      @(negedge clk);
      chk("sweep_ack_count", 32'(ack_rises - rises0), 10);
    end

    // CPU store colliding with a forced debug read of addr 4 (old value 6)
    for (int k = 0; k < 8; k++) drive(1,0,200,0, 1,4);
    @(negedge clk);
    chk("st_wait_full", 32'(wait_cnt), 32'(MAX_WAIT - 1));
    drive(0,1,4,3, 1,4);
    @(negedge clk);
    chk("st_stall", 32'(bus.cpu_stall), 1);
    chk("st_blocked_we", 32'(bus.mem_we), 0);
    chk("st_dbg_addr", 32'(bus.mem_addr), 4);
    drive(0,1,4,3, 1,4);
    @(negedge clk);
    chk("st_retry_stall", 32'(bus.cpu_stall), 0);
    chk("st_retry_we", 32'(bus.mem_we), 1);
    chk("st_read_state", 32'(fsm_state), 1);
    drive(0,0,0,0, 1,4);
    @(negedge clk);
    chk("st_old_ack", 32'(bus.dbg_ack), 1);
    chk("st_old_rdata", bus.dbg_rdata, 6);
    drive(0,0,0,0, 0,4);
    wait_ack(1'b0, "st_ack_lo");
    drive(0,0,0,0, 1,4);
    wait_ack(1'b1, "st2_ack_hi");
    chk("st_new_rdata", bus.dbg_rdata, 3);
    drive(0,0,0,0, 0,4);
    wait_ack(1'b0, "st2_ack_lo");

    // reset asserted during READ (mem[2]=8): capture discarded
    drive(0,0,0,0, 1,2);
    @(negedge clk);
    chk("rr_issue_addr", 32'(bus.mem_addr), 2);
    drive(0,0,0,0, 1,2);
    @(negedge clk);
    chk("rr_in_read", 32'(fsm_state), 1);
    #1 rst = 1'b1;
    #1;
    chk("rr_ack", 32'(bus.dbg_ack), 0);
    chk("rr_state", 32'(fsm_state), 0);
    chk("rr_rdata", bus.dbg_rdata, 0);
    drive(0,0,0,0, 0,2);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_no_capture", bus.dbg_rdata, 0);
    chk("rr_ack_after", 32'(bus.dbg_ack), 0);
    drive(0,0,0,0, 1,2);
    wait_ack(1'b1, "rr_next_ack");
    chk("rr_next_rdata", bus.dbg_rdata, 8);
    drive(0,0,0,0, 0,2);
    wait_ack(1'b0, "rr_next_ack_lo");

    // idle CPU gap at wait_cnt=2 (mem[7]=3)
    drive(1,0,300,0, 1,7);
    drive(1,0,301,0, 1,7);
    drive(0,0,0,0, 1,7);
    @(negedge clk);
    chk("gap_wait", 32'(wait_cnt), 2);
    chk("gap_issue_addr", 32'(bus.mem_addr), 7);
    chk("gap_issue_en", 32'(bus.mem_en), 1);
    chk("gap_no_stall", 32'(bus.cpu_stall), 0);
    wait_ack(1'b1, "gap_ack_hi");
    chk("gap_rdata", bus.dbg_rdata, 3);
    drive(0,0,0,0, 0,7);
    wait_ack(1'b0, "gap_ack_lo");
    chk("gap_wait_clr", 32'(wait_cnt), 0);
    chk("gap_state", 32'(fsm_state), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
